key_event_sequencer: RTL and testbench

KEY_EVENT_SEQUENCER -- requirements
Module: key_event_sequencer

---
 rtl/key_event_sequencer.sv | 78 +++++++
 tb/tb_key_event_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/key_event_sequencer.sv
// key_event_sequencer: PS/2 scan-code decoder queuing make events in a 4-deep FIFO (optional TYPEMATIC_FILTER_EN)
module key_event_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] keycode,
  input  logic        kflag,
  output logic        evt_valid,
  output logic [7:0]  evt_code,
  input  logic        evt_ready,
  output logic [2:0]  fifo_count,
  output logic        overflow,
  input  logic        ovf_clr,
  output logic [7:0]  held_code
);
  typedef enum logic [1:0] {IDLE = 2'd0, DECODE = 2'd1, PUSH = 2'd2} state_t;
  state_t      state;
  logic [15:0] kc_r;
  logic [7:0]  mem [4];
  logic [1:0]  wp, rp;
  logic [2:0]  cnt;
  logic        push, pop, wr, ovf_set;
  assign push       = state == PUSH;
  assign pop        = evt_valid & evt_ready;
  assign wr         = push & ((cnt != 3'd4) | pop);
  assign ovf_set    = (kflag & ((state == DECODE) | (state == PUSH))) | (push & ~wr);
  assign evt_valid  = cnt != 3'd0;
  assign evt_code   = mem[rp];
  assign fifo_count = cnt;
  // control FSM: capture, classify prefix/break/make, then push
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      kc_r      <= 16'h0000;
      held_code <= 8'h00;
    end else begin
      case (state)
        IDLE: if (kflag) begin
          kc_r  <= keycode;
          state <= DECODE;
        end
        DECODE:
          if (kc_r[7:0] == 8'hF0 || kc_r[7:0] == 8'hE0) state <= IDLE;
          else if (kc_r[15:8] == 8'hF0) begin
            if (kc_r[7:0] == held_code) held_code <= 8'h00;
            state <= IDLE;
          end
`ifdef TYPEMATIC_FILTER_EN
          else if (held_code != 8'h00 && kc_r[7:0] == held_code) state <= IDLE;
`endif
          else state <= PUSH;
        PUSH: begin
          held_code <= kc_r[7:0];
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  // circular event FIFO; a pop frees the head slot so a simultaneous push fits even when full
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp  <= 2'd0;
      rp  <= 2'd0;
      cnt <= 3'd0;
      for (int i = 0; i < 4; i++) mem[i] <= 8'h00;
    end else begin
      if (wr) begin
        mem[wp] <= kc_r[7:0];
        wp      <= wp + 2'd1;
      end
      if (pop) rp <= rp + 2'd1;
      cnt <= cnt + 3'(wr) - 3'(pop);
    end
  // sticky overflow; a new drop wins over a same-cycle clear
  always_ff @(posedge clk or posedge rst)
    if (rst) overflow <= 1'b0;
    else if (ovf_set) overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
endmodule

// File: tb/tb_key_event_sequencer.sv
// tb_key_event_sequencer: directed self-checking bench for key_event_sequencer
module tb_key_event_sequencer;
  logic        clk = 0, rst = 0, kflag = 0, evt_ready = 0, ovf_clr = 0;
  logic [15:0] keycode = 16'h0000;
  logic        evt_valid, overflow;
  logic [7:0]  evt_code, held_code;
  logic [2:0]  fifo_count;
  int n_chk = 0, n_fail = 0;

  key_event_sequencer dut (
    .clk(clk), .rst(rst), .keycode(keycode), .kflag(kflag),
    .evt_valid(evt_valid), .evt_code(evt_code), .evt_ready(evt_ready),
    .fifo_count(fifo_count), .overflow(overflow), .ovf_clr(ovf_clr),
    .held_code(held_code)
  );

  always #5 clk = ~clk;

  // kflag high for one cycle N; returns at the negedge of N+1 (DECODE)
  task automatic pulse(input logic [15:0] code);
    @(negedge clk);
    keycode = code;
    kflag = 1;
    @(negedge clk);
    kflag = 0;
  endtask

  // returns at the negedge of N+2 (PUSH cycle, FIFO not yet written)
  task automatic make(input logic [15:0] code);
    pulse(code);
    @(negedge clk);
  endtask

  task automatic drain();
    evt_ready = 1;
    repeat (5) @(negedge clk);
    evt_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    #1;
    n_chk++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", evt_valid); end
    n_chk++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
    n_chk++; if (evt_code !== 8'h00) begin n_fail++; $display("FAIL reset_code got %h exp 00", evt_code); end
    n_chk++; if (held_code !== 8'h00) begin n_fail++; $display("FAIL reset_held got %h exp 00", held_code); end
    n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b exp 0", overflow); end
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_single_key();
    evt_ready = 1;
    pulse(16'h001C);
    @(negedge clk);
    n_chk++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL single_n2_valid got %b exp 0", evt_valid); end
    @(negedge clk);
    n_chk++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL single_n3_valid got %b exp 1", evt_valid); end
    n_chk++; if (evt_code !== 8'h1C) begin n_fail++; $display("FAIL single_code got %h exp 1C", evt_code); end
    n_chk++; if (held_code !== 8'h1C) begin n_fail++; $display("FAIL single_held got %h exp 1C", held_code); end
    @(negedge clk);
    n_chk++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL single_n4_valid got %b exp 0", evt_valid); end
    pulse(16'hF01C);
    @(negedge clk);
    n_chk++; if (held_code !== 8'h00) begin n_fail++; $display("FAIL break_held got %h exp 00", held_code); end
    @(negedge clk);
    n_chk++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL break_valid got %b exp 0", evt_valid); end
    evt_ready = 0;
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_q [4] = '{8'h15, 8'h1D, 8'h24, 8'h2D};
    evt_ready = 0;
    make(16'h0015);
    make(16'h001D);
    make(16'h0024);
    make(16'h002D);
    make(16'h002C);
    @(negedge clk);
    n_chk++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL full_count got %0d exp 4", fifo_count); end
    n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL full_ovf got %b exp 1", overflow); end
    n_chk++; if (held_code !== 8'h2C) begin n_fail++; $display("FAIL full_held got %h exp 2C", held_code); end
    repeat (2) @(negedge clk);
    n_chk++; if (evt_code !== 8'h15) begin n_fail++; $display("FAIL stall_code got %h exp 15", evt_code); end
    ovf_clr = 1;
    @(negedge clk);
    ovf_clr = 0;
    n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr got %b exp 0", overflow); end
    evt_ready = 1;
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (evt_valid !== 1'b1 || evt_code !== exp_q[i]) begin n_fail++; $display("FAIL pop_order[%0d] got %b/%h exp 1/%h", i, evt_valid, evt_code, exp_q[i]); end
      @(negedge clk);
    end
    n_chk++; if (fifo_count !== 3'd0 || evt_valid !== 1'b0) begin n_fail++; $display("FAIL drained got %0d/%b exp 0/0", fifo_count, evt_valid); end
    evt_ready = 0;
  endtask

  task automatic test_push_pop_full();
    logic [7:0] exp_q [4] = '{8'h12, 8'h13, 8'h14, 8'h55};
    make(16'h0011);
    make(16'h0012);
    make(16'h0013);
    make(16'h0014);
    make(16'h0055);
    evt_ready = 1;
    @(negedge clk);
    evt_ready = 0;
    n_chk++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL pushpop_count got %0d exp 4", fifo_count); end
    n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL pushpop_ovf got %b exp 0", overflow); end
    evt_ready = 1;
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (evt_code !== exp_q[i]) begin n_fail++; $display("FAIL pushpop_order[%0d] got %h exp %h", i, evt_code, exp_q[i]); end
      @(negedge clk);
    end
    evt_ready = 0;
  endtask

  task automatic test_typematic();
`ifdef TYPEMATIC_FILTER_EN
    logic [2:0] exp_n = 3'd1;
`else
    logic [2:0] exp_n = 3'd3;
`endif
    make(16'h001C);
    make(16'h001C);
    make(16'h001C);
    @(negedge clk);
    n_chk++; if (fifo_count !== exp_n) begin n_fail++; $display("FAIL typematic_count got %0d exp %0d", fifo_count, exp_n); end
    drain();
    make(16'hF01C);
    n_chk++; if (held_code !== 8'h00) begin n_fail++; $display("FAIL typematic_break got %h exp 00", held_code); end
  endtask

  task automatic test_prefix_collision();
    make(16'h75E0);
    make(16'h00F0);
    @(negedge clk);
    n_chk++; if (evt_valid !== 1'b0 || held_code !== 8'h00) begin n_fail++; $display("FAIL prefix got %b/%h exp 0/00", evt_valid, held_code); end
    @(negedge clk);
    keycode = 16'h0033; kflag = 1;
    @(negedge clk);
    keycode = 16'h0034;
    @(negedge clk);
    kflag = 0;
    n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL collide_ovf got %b exp 1", overflow); end
    @(negedge clk);
    n_chk++; if (fifo_count !== 3'd1 || evt_code !== 8'h33) begin n_fail++; $display("FAIL collide_evt got %0d/%h exp 1/33", fifo_count, evt_code); end
    ovf_clr = 1;
    @(negedge clk);
    ovf_clr = 0;
    n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL collide_clr got %b exp 0", overflow); end
    keycode = 16'h0036; kflag = 1;
    @(negedge clk);
    keycode = 16'h0037; ovf_clr = 1;
    @(negedge clk);
    kflag = 0; ovf_clr = 0;
    n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL set_over_clr got %b exp 1", overflow); end
    ovf_clr = 1;
    @(negedge clk);
    ovf_clr = 0;
  endtask

  task automatic test_reset_midflight();
    n_chk++; if (fifo_count !== 3'd2) begin n_fail++; $display("FAIL pre_reset_count got %0d exp 2", fifo_count); end
    pulse(16'h0044);
    rst = 1;
    #1;
    n_chk++; if (evt_valid !== 1'b0 || fifo_count !== 3'd0) begin n_fail++; $display("FAIL midreset got %b/%0d exp 0/0", evt_valid, fifo_count); end
    n_chk++; if (held_code !== 8'h00 || evt_code !== 8'h00) begin n_fail++; $display("FAIL midreset_regs got %h/%h exp 00/00", held_code, evt_code); end
    @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    n_chk++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL inflight_dropped got %b exp 0", evt_valid); end
    make(16'h002B);
    @(negedge clk);
    n_chk++; if (fifo_count !== 3'd1 || evt_code !== 8'h2B) begin n_fail++; $display("FAIL after_reset got %0d/%h exp 1/2B", fifo_count, evt_code); end
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_backpressure();
    test_push_pop_full();
    test_typematic();
    test_prefix_collision();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end
endmodule
